// File: rtl/prbs_pkg.sv
// Shared types and constants for the WiMAX randomizer block sequencer.
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACTIVE,
        DONE
    } state_t;

    localparam int PRBS_W = 15;

    // MSB corresponds to register stage 1 of the 1+x^14+x^15 generator.
    localparam logic [PRBS_W-1:0] SEED_DEFAULT_C = 15'h4A80;

endpackage

// File: rtl/prbs_block_sequencer.sv
// Drives seed load / advance for the WiMAX PRBS one FEC block at a time.
// Optional macro PRBS_SEED_CFG_EN adds a per-burst seed_cfg input.
module prbs_block_sequencer
    import prbs_pkg::*;
#(
    parameter int                BLOCK_BITS   = 96,
    parameter logic [PRBS_W-1:0] SEED_DEFAULT = SEED_DEFAULT_C,
    localparam int               CNT_W        = $clog2(BLOCK_BITS)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              ready_in,
    output logic              valid_out,
    output logic              prbs_load,
    output logic              prbs_en,
    output logic [PRBS_W-1:0] prbs_seed,
    output logic              first_out,
    output logic              last_out,
    output logic              block_done,
`ifdef PRBS_SEED_CFG_EN
    input  logic [PRBS_W-1:0] seed_cfg,
`endif
    input  logic              abort
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_BITS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             at_last;

    assign at_last = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready_out  = 1'b0;
        valid_out  = 1'b0;
        prbs_load  = 1'b0;
        prbs_en    = 1'b0;
        first_out  = 1'b0;
        last_out   = 1'b0;
        block_done = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                prbs_load  = 1'b1;
                state_next = ACTIVE;
            end
            ACTIVE: begin
                ready_out = ready_in;
                valid_out = valid_in;
                xfer      = valid_in & ready_in;
                prbs_en   = xfer;
                first_out = valid_in & (cnt == '0);
                last_out  = valid_in & at_last;
                if (xfer && at_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                block_done = 1'b1;
                state_next = valid_in ? LOAD : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Abort only redirects the next state; this cycle's outputs stand.
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN || abort) begin
            cnt <= '0;
        end else if (state == LOAD) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

`ifdef PRBS_SEED_CFG_EN
    logic [PRBS_W-1:0] seed_q;

    // Only sampled between blocks so a running block keeps its seed.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            seed_q <= SEED_DEFAULT;
        end else if (state == IDLE || state == DONE) begin
            seed_q <= seed_cfg;
        end
    end

    assign prbs_seed = seed_q;
`else
    assign prbs_seed = SEED_DEFAULT;
`endif

endmodule

// File: tb/tb_prbs_block_sequencer.sv
// Scoreboard bench for prbs_block_sequencer; exercises the seed_cfg path
// only when PRBS_SEED_CFG_EN is defined.
module tb_prbs_block_sequencer;

    localparam int          BB       = 96;
    localparam logic [14:0] SEED_DEF = 15'h4A80;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b0;
    logic        abort = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic        prbs_load;
    logic        prbs_en;
    logic [14:0] prbs_seed;
    logic        first_out;
    logic        last_out;
    logic        block_done;
`ifdef PRBS_SEED_CFG_EN
    logic [14:0] seed_cfg = SEED_DEF;
`endif

    int          checks = 0;
    int          failures = 0;
    int          exp_q[$];
    logic [14:0] exp_seed = SEED_DEF;
    logic        kill_pending = 1'b0;
    logic        mon_en = 1'b0;
    logic        done_due = 1'b0;

    prbs_block_sequencer #(.BLOCK_BITS(BB), .SEED_DEFAULT(SEED_DEF)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .prbs_load  (prbs_load),
        .prbs_en    (prbs_en),
        .prbs_seed  (prbs_seed),
        .first_out  (first_out),
        .last_out   (last_out),
        .block_done (block_done),
`ifdef PRBS_SEED_CFG_EN
        .seed_cfg   (seed_cfg),
`endif
        .abort      (abort)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The expected output stream is every block's bit indices 0..BB-1 in order.
    task automatic pushBlock();
        for (int k = 0; k < BB; k++) begin
            exp_q.push_back(k);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic a, input logic rn = 1'b1);
        @(posedge clk);
        #1;
        if (kill_pending) begin
            exp_q.delete();
            kill_pending = 1'b0;
        end
        if (exp_q.size() < BB) begin
            pushBlock();
        end
        valid_in = v;
        ready_in = r;
        abort    = a;
        resetN   = rn;
        kill_pending = a | ~rn;
        #3;
    endtask

    // Monitor: pops one expected index per accepted output bit.
    always @(negedge clk) begin
        int k;
        if (mon_en) begin
            checkOutput("load_en_exclusive", {31'b0, prbs_load & prbs_en}, 32'd0);
            checkOutput("block_done_timing", {31'b0, block_done}, {31'b0, done_due});
            done_due = 1'b0;
            if (prbs_load) begin
                checkOutput("seed_at_load", {17'b0, prbs_seed}, {17'b0, exp_seed});
            end
            if (valid_out) begin
                checkOutput("valid_has_source", {31'b0, valid_in}, 32'd1);
                if (exp_q.size() == 0) begin
                    checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
                end else begin
                    k = exp_q[0];
                    checkOutput("first_out", {31'b0, first_out}, {31'b0, k == 0});
                    checkOutput("last_out", {31'b0, last_out}, {31'b0, k == BB - 1});
                    checkOutput("prbs_en_xfer", {31'b0, prbs_en}, {31'b0, ready_in});
                    if (ready_in && resetN && !abort) begin
                        void'(exp_q.pop_front());
                        if (k == BB - 1) begin
                            done_due = 1'b1;
                        end
                    end
                end
            end else begin
                checkOutput("prbs_en_no_valid", {31'b0, prbs_en}, 32'd0);
                checkOutput("first_no_valid", {31'b0, first_out}, 32'd0);
                checkOutput("last_no_valid", {31'b0, last_out}, 32'd0);
            end
        end
    end

    initial begin
        int  en_cnt;
        int  ph;
        int  cnt_e;
        logic seen;
        logic exp_vout;

        pushBlock();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("reset_valid_out", {31'b0, valid_out}, 32'd0);
        checkOutput("reset_ready_out", {31'b0, ready_out}, 32'd0);
        checkOutput("reset_prbs_load", {31'b0, prbs_load}, 32'd0);
        checkOutput("reset_prbs_en", {31'b0, prbs_en}, 32'd0);
        checkOutput("reset_block_done", {31'b0, block_done}, 32'd0);
        checkOutput("reset_seed", {17'b0, prbs_seed}, {17'b0, SEED_DEF});
        mon_en = 1'b1;

        $display("[TB] continuous stream, 200 cycles");
        en_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(1, 1, 0);
            ph = (c - 1) % (BB + 2);
            exp_vout = (c > 0) && (ph >= 1) && (ph <= BB);
            checkOutput("t1_prbs_load", {31'b0, prbs_load}, {31'b0, (c > 0) && (ph == 0)});
            checkOutput("t1_block_done", {31'b0, block_done}, {31'b0, (c > 0) && (ph == BB + 1)});
            checkOutput("t1_valid_out", {31'b0, valid_out}, {31'b0, exp_vout});
            checkOutput("t1_ready_out", {31'b0, ready_out}, {31'b0, exp_vout});
            if (exp_vout) begin
                checkOutput("t1_first", {31'b0, first_out}, {31'b0, ph == 1});
                checkOutput("t1_last", {31'b0, last_out}, {31'b0, ph == BB});
            end
            if (prbs_en) en_cnt++;
        end
        checkOutput("t1_prbs_en_count", en_cnt, 2 * BB + 2);

        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        checkOutput("idle_valid_out", {31'b0, valid_out}, 32'd0);
        checkOutput("idle_ready_out", {31'b0, ready_out}, 32'd0);

        $display("[TB] ready_in toggling");
        applyStimulus(1, 1, 0);
        checkOutput("t2_idle_load", {31'b0, prbs_load}, 32'd0);
        applyStimulus(1, 1, 0);
        checkOutput("t2_load", {31'b0, prbs_load}, 32'd1);
        checkOutput("t2_load_ready", {31'b0, ready_out}, 32'd0);
        for (int j = 0; j < 2 * BB - 1; j++) begin
            applyStimulus(1, (j % 2) == 0, 0);
            cnt_e = (j + 1) / 2;
            checkOutput("t2_first", {31'b0, first_out}, {31'b0, cnt_e == 0});
            checkOutput("t2_last", {31'b0, last_out}, {31'b0, cnt_e == BB - 1});
            checkOutput("t2_prbs_en", {31'b0, prbs_en}, {31'b0, (j % 2) == 0});
            checkOutput("t2_ready_out", {31'b0, ready_out}, {31'b0, (j % 2) == 0});
            checkOutput("t2_no_done", {31'b0, block_done}, 32'd0);
        end
        applyStimulus(0, 1, 0);
        checkOutput("t2_done", {31'b0, block_done}, 32'd1);
        checkOutput("t2_done_ready", {31'b0, ready_out}, 32'd0);

        $display("[TB] valid dropped after block end");
        applyStimulus(0, 1, 0);
        checkOutput("t6_idle_ready", {31'b0, ready_out}, 32'd0);
        checkOutput("t6_idle_load", {31'b0, prbs_load}, 32'd0);
        checkOutput("t6_idle_done", {31'b0, block_done}, 32'd0);
        applyStimulus(1, 1, 0);
        checkOutput("t6_idle_valid_load", {31'b0, prbs_load}, 32'd0);
        applyStimulus(1, 1, 0);
        checkOutput("t6_load", {31'b0, prbs_load}, 32'd1);

        $display("[TB] abort at bit 40");
        for (int b = 0; b <= 40; b++) begin
            applyStimulus(1, 1, b == 40);
            checkOutput("t3_first", {31'b0, first_out}, {31'b0, b == 0});
        end
        applyStimulus(1, 1, 0);
        checkOutput("t3_idle_valid", {31'b0, valid_out}, 32'd0);
        checkOutput("t3_idle_done", {31'b0, block_done}, 32'd0);
        checkOutput("t3_idle_load", {31'b0, prbs_load}, 32'd0);
        applyStimulus(1, 1, 0);
        checkOutput("t3_reload", {31'b0, prbs_load}, 32'd1);
        applyStimulus(1, 1, 0);
        checkOutput("t3_first_after", {31'b0, first_out}, 32'd1);

        $display("[TB] reset at bit 50");
        for (int b = 1; b < 50; b++) begin
            applyStimulus(1, 1, 0);
        end
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_valid_out", {31'b0, valid_out}, 32'd0);
        checkOutput("t4_ready_out", {31'b0, ready_out}, 32'd0);
        checkOutput("t4_prbs_load", {31'b0, prbs_load}, 32'd0);
        checkOutput("t4_prbs_en", {31'b0, prbs_en}, 32'd0);
        checkOutput("t4_first", {31'b0, first_out}, 32'd0);
        checkOutput("t4_last", {31'b0, last_out}, 32'd0);
        checkOutput("t4_block_done", {31'b0, block_done}, 32'd0);
        checkOutput("t4_seed", {17'b0, prbs_seed}, {17'b0, SEED_DEF});
        en_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            applyStimulus(1, 1, 0);
            if (prbs_en) en_cnt++;
            if (block_done) seen = 1'b1;
        end
        checkOutput("t4_done_seen", {31'b0, seen}, 32'd1);
        checkOutput("t4_full_block", en_cnt, BB);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 4) != 0,
                          ($urandom % 256) == 0, ($urandom % 512) != 0);
        end

`ifdef PRBS_SEED_CFG_EN
        $display("[TB] configurable seed");
        applyStimulus(0, 0, 1);
        seed_cfg = 15'h7FFF;
        exp_seed = 15'h7FFF;
        applyStimulus(0, 0, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        checkOutput("t5_load", {31'b0, prbs_load}, 32'd1);
        checkOutput("t5_seed_load", {17'b0, prbs_seed}, 32'h7FFF);
        seed_cfg = 15'h1234;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, 0);
            checkOutput("t5_seed_held", {17'b0, prbs_seed}, 32'h7FFF);
        end
        exp_seed = 15'h1234;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            applyStimulus(1, 1, 0);
            if (prbs_load) begin
                seen = 1'b1;
                checkOutput("t5_seed_next", {17'b0, prbs_seed}, 32'h1234);
            end
        end
        checkOutput("t5_next_load_seen", {31'b0, seen}, 32'd1);
`endif

        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
